// File: rtl/led_status_pkg.sv
// Shared types and helpers for the LED status driver.
// LED_STATUS_GAMMA_EN selects a squared (gamma) duty curve instead of linear.
package led_status_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RISE = 2'd1,
    ST_ON   = 2'd2,
    ST_FALL = 2'd3
  } state_t;

  // Widest brightness the helpers support; callers zero-extend into this.
  localparam int MAX_BITS = 16;

  function automatic logic [MAX_BITS-1:0] max_level(input int bits);
    logic [MAX_BITS-1:0] ones;
    ones = '1;
    return ones >> (MAX_BITS - bits);
  endfunction

  function automatic logic [MAX_BITS-1:0] duty_of(input logic [MAX_BITS-1:0] lvl,
                                                  input int                  bits);
`ifdef LED_STATUS_GAMMA_EN
    logic [2*MAX_BITS-1:0] sq;
    sq = {{MAX_BITS{1'b0}}, lvl} * {{MAX_BITS{1'b0}}, lvl};
    return MAX_BITS'(sq >> bits);
`else
    return lvl & max_level(bits);
`endif
  endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// Free-running PWM counter and duty compare; full brightness is forced solid on.
// Duty curve follows LED_STATUS_GAMMA_EN through led_status_pkg::duty_of.
module led_pwm_gen
  import led_status_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [PWM_BITS-1:0] level,
  output logic                led_out
);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [MAX_BITS-1:0] level_ext;
  logic [MAX_BITS-1:0] cnt_ext;
  logic [MAX_BITS-1:0] duty;

  always_comb begin
    level_ext = MAX_BITS'(level);
    cnt_ext   = MAX_BITS'(pwm_cnt);
    duty      = duty_of(level_ext, PWM_BITS);
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      pwm_cnt <= '0;
      led_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      led_out <= (level_ext == max_level(PWM_BITS)) || (cnt_ext < duty);
    end
  end

endmodule

// File: rtl/led_status_driver.sv
// Fades LEDR in/out from the filtered PIO bit and runs an independent heartbeat.
// Build with LED_STATUS_GAMMA_EN defined for a gamma-corrected PWM duty.
//
// state | meaning
// OFF   | dark, level held at 0, waiting for filtered input
// RISE  | level steps up once per prescaler tick
// ON    | full brightness, waiting for input to drop
// FALL  | level steps down once per prescaler tick
module led_status_driver
  import led_status_pkg::*;
#(
  parameter int PWM_BITS      = 8,
  parameter int FILTER_CYCLES = 16,
  parameter int FADE_DIV      = 50000,
  parameter int HB_DIV        = 25000000
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                ledr_in,
  input  logic                enable,
  output logic                led_out,
  output logic [PWM_BITS-1:0] level,
  output logic                busy,
  output logic                heartbeat_out
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int PW = $clog2(FADE_DIV + 1);
  localparam int HW = $clog2(HB_DIV + 1);
  localparam logic [FW-1:0] F_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [PW-1:0] P_LAST = PW'(FADE_DIV - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HB_DIV - 1);
  localparam logic [PWM_BITS-1:0] LVL_MAX = PWM_BITS'(max_level(PWM_BITS));
  localparam logic [PWM_BITS-1:0] LVL_ONE = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] LVL_PRE = LVL_MAX - LVL_ONE;

  logic          sync1, sync2, filt, filt_d;
  logic [FW-1:0] filt_cnt;
  logic [PW-1:0] presc;
  logic          tick;
  logic [HW-1:0] hb_cnt;
  state_t        state;

  // The FSM reacts to the filter's next value so it moves on the same edge filt does.
  always_comb begin
    filt_d = filt;
    if ((sync2 != filt) && (filt_cnt == F_LAST)) filt_d = sync2;
  end

  assign tick = (presc == P_LAST);

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      filt     <= 1'b0;
      filt_cnt <= '0;
    end else begin
      sync1 <= ledr_in;
      sync2 <= sync1;
      filt  <= filt_d;
      if ((sync2 != filt) && (filt_cnt != F_LAST)) filt_cnt <= filt_cnt + 1'b1;
      else                                         filt_cnt <= '0;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n || !enable) begin
      state <= ST_OFF;
      level <= '0;
      busy  <= 1'b0;
      presc <= '0;
    end else begin
      unique case (state)
        ST_OFF: begin
          presc <= '0;
          if (filt_d) begin
            state <= ST_RISE;
            busy  <= 1'b1;
          end
        end
        ST_RISE: begin
          if (!filt_d) begin
            state <= ST_FALL;
            presc <= '0;
          end else if (level == LVL_MAX) begin
            state <= ST_ON;
            busy  <= 1'b0;
            presc <= '0;
          end else if (tick) begin
            level <= level + 1'b1;
            presc <= '0;
            if (level == LVL_PRE) begin
              state <= ST_ON;
              busy  <= 1'b0;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        ST_ON: begin
          presc <= '0;
          if (!filt_d) begin
            state <= ST_FALL;
            busy  <= 1'b1;
          end
        end
        ST_FALL: begin
          if (filt_d) begin
            state <= ST_RISE;
            presc <= '0;
          end else if (level == '0) begin
            state <= ST_OFF;
            busy  <= 1'b0;
            presc <= '0;
          end else if (tick) begin
            level <= level - 1'b1;
            presc <= '0;
            if (level == LVL_ONE) begin
              state <= ST_OFF;
              busy  <= 1'b0;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        default: begin
          state <= ST_OFF;
          level <= '0;
          busy  <= 1'b0;
          presc <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      hb_cnt        <= '0;
      heartbeat_out <= 1'b0;
    end else if (hb_cnt == H_LAST) begin
      hb_cnt        <= '0;
      heartbeat_out <= ~heartbeat_out;
    end else begin
      hb_cnt <= hb_cnt + 1'b1;
    end
  end

  led_pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .level        (level),
    .led_out      (led_out)
  );

endmodule

// File: tb/tb_led_status_driver.sv
// Bench for led_status_driver: cycle model of the fade/filter/heartbeat rules plus directed scenarios.
// Expected PWM duty follows LED_STATUS_GAMMA_EN when the bench is built with it.
module tb_led_status_driver;

  localparam int PB   = 4;
  localparam int FC   = 4;
  localparam int FD   = 4;
  localparam int HB   = 8;
  localparam int LMAX = 15;
  localparam int NPWM = 16;

  logic          clk = 1'b0;
  logic          reset_reset_n = 1'b0;
  logic          ledr_in = 1'b1;
  logic          enable = 1'b0;
  logic          led_out, busy, heartbeat_out;
  logic [PB-1:0] level;
  logic [PB-1:0] ref_level = '0;
  logic          ref_led;

  int checks = 0;
  int failures = 0;

  led_status_driver #(
    .PWM_BITS(PB), .FILTER_CYCLES(FC), .FADE_DIV(FD), .HB_DIV(HB)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(reset_reset_n),
    .ledr_in      (ledr_in),
    .enable       (enable),
    .led_out      (led_out),
    .level        (level),
    .busy         (busy),
    .heartbeat_out(heartbeat_out)
  );

  led_pwm_gen #(.PWM_BITS(PB)) u_pwm (
    .clk_clk      (clk),
    .reset_reset_n(reset_reset_n),
    .level        (ref_level),
    .led_out      (ref_led)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int duty_model(int l);
`ifdef LED_STATUS_GAMMA_EN
    return (l * l) / NPWM;
`else
    return l;
`endif
  endfunction

  // Model: phase 0=off 1=rise 2=on 3=fall; age counts cycles spent in the current fade.
  int m_phase, m_level, m_age, m_cyc;
  bit m_led, m_filt, m_started;
  bit raw[$];
  bit win[$];

  always @(posedge clk) begin
    bit seen, fnew, differ;
    int prev_level;
    m_started = 1'b1;
    if (!reset_reset_n) begin
      m_phase = 0; m_level = 0; m_age = 0; m_cyc = 0;
      m_led = 1'b0; m_filt = 1'b0;
      raw.delete(); raw.push_back(1'b0); raw.push_back(1'b0);
      win.delete();
    end else begin
      prev_level = m_level;
      m_cyc++;
      raw.push_back(ledr_in);
      seen = raw.pop_front();
      win.push_back(seen);
      if (win.size() > FC) void'(win.pop_front());
      fnew = m_filt;
      if (win.size() == FC) begin
        differ = 1'b1;
        foreach (win[i]) if (win[i] == m_filt) differ = 1'b0;
        if (differ) fnew = !m_filt;
      end
      m_filt = fnew;
      if (!enable) begin
        m_phase = 0; m_level = 0; m_age = 0;
      end else begin
        case (m_phase)
          0: if (fnew) begin m_phase = 1; m_age = 0; end
          1: begin
            if (!fnew) begin m_phase = 3; m_age = 0; end
            else if (m_level == LMAX) m_phase = 2;
            else begin
              m_age++;
              if (m_age % FD == 0) m_level++;
              if (m_level == LMAX) m_phase = 2;
            end
          end
          2: if (!fnew) begin m_phase = 3; m_age = 0; end
          default: begin
            if (fnew) begin m_phase = 1; m_age = 0; end
            else if (m_level == 0) m_phase = 0;
            else begin
              m_age++;
              if (m_age % FD == 0) m_level--;
              if (m_level == 0) m_phase = 0;
            end
          end
        endcase
      end
      m_led = (prev_level == LMAX) || (((m_cyc - 1) % NPWM) < duty_model(prev_level));
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("model_level", int'(level), m_level);
      check("model_busy", int'(busy), int'(m_phase == 1 || m_phase == 3));
      check("model_led_out", int'(led_out), int'(m_led));
      check("model_heartbeat", int'(heartbeat_out), (m_cyc / HB) % 2);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int idx, idx2, cnt, peak, maxstep, prev, step;
    int lv[4];
    int exp_hi[4];
    lv = '{0, 5, 9, 15};
`ifdef LED_STATUS_GAMMA_EN
    exp_hi = '{0, 1, 5, 16};
`else
    exp_hi = '{0, 5, 9, 16};
`endif

    // Reset held with ledr_in high
    wait_cycles(3);
    check("rst_level", int'(level), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_led", int'(led_out), 0);
    check("rst_hb", int'(heartbeat_out), 0);
    reset_reset_n = 1'b1;
    ledr_in = 1'b0;
    idx = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (heartbeat_out && idx == 0) idx = i;
    end
    check("hb_first_high", idx, 8);

    // Glitch rejection
    enable = 1'b1;
    wait_cycles(8);
    ledr_in = 1'b1;
    wait_cycles(3);
    ledr_in = 1'b0;
    wait_cycles(12);
    check("glitch_busy", int'(busy), 0);
    check("glitch_level", int'(level), 0);

    // Accepted input and full fade-in
    ledr_in = 1'b1;
    idx = 0; idx2 = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (busy && idx == 0) idx = i;
      if (level == LMAX && idx2 == 0) begin idx2 = i; break; end
    end
    check("busy_latency", idx, 6);
    check("fade_in_done", idx2, 66);
    check("on_busy", int'(busy), 0);
    cnt = 0;
    repeat (16) begin @(negedge clk); cnt += int'(led_out); end
    check("on_led_solid", cnt, 16);

    // Full fade-out
    ledr_in = 1'b0;
    idx = 0;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      if (level == 0 && !busy) begin idx = i; break; end
    end
    check("fade_out_done", idx, 66);

    // Reversal at level 7
    ledr_in = 1'b1;
    idx = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (level == 7) begin idx = i; break; end
    end
    check("reach_level7", idx, 34);
    ledr_in = 1'b0;
    peak = 7; maxstep = 0; prev = 7; idx = 0;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (int'(level) > peak) peak = int'(level);
      step = (int'(level) > prev) ? int'(level) - prev : prev - int'(level);
      if (step > maxstep) maxstep = step;
      prev = int'(level);
      if (level == 0 && !busy) begin idx = i; break; end
    end
    check("rev_peak", peak, 8);
    check("rev_max_step", maxstep, 1);
    check("rev_done", idx, 38);

    // Enable override from ON
    ledr_in = 1'b1;
    idx = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (level == LMAX && !busy) begin idx = i; break; end
    end
    check("reach_on_again", idx, 66);
    enable = 1'b0;
    @(negedge clk);
    check("dis_level", int'(level), 0);
    check("dis_busy", int'(busy), 0);
    check("dis_led_lag", int'(led_out), 1);
    @(negedge clk);
    check("dis_led", int'(led_out), 0);

    // Re-enable then reset mid-fade
    enable = 1'b1;
    wait_cycles(10);
    check("reenable_busy", int'(busy), 1);
    reset_reset_n = 1'b0;
    wait_cycles(2);
    check("midfade_rst_level", int'(level), 0);
    check("midfade_rst_busy", int'(busy), 0);
    check("midfade_rst_led", int'(led_out), 0);
    check("midfade_rst_hb", int'(heartbeat_out), 0);
    reset_reset_n = 1'b1;
    ledr_in = 1'b0;
    wait_cycles(20);

    // PWM duty on a directly driven generator
    for (int k = 0; k < 4; k++) begin
      ref_level = PB'(lv[k]);
      wait_cycles(2);
      cnt = 0;
      repeat (NPWM) begin @(negedge clk); cnt += int'(ref_led); end
      check($sformatf("pwm_high_lvl%0d", lv[k]), cnt, exp_hi[k]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
